// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: pipeline-side status in, stall/flush controls out.
// master = pipeline side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ID_EX_MemRead_i;
    logic [4:0]       ID_EX_RD_i;
    logic [4:0]       IF_ID_RS1_i;
    logic [4:0]       IF_ID_RS2_i;
    logic             IF_ID_UsesRs2_i;
    logic             branch_taken_i;
    logic             ID_EX_Multicycle_i;
    logic             mc_done_i;
    logic             pc_write_o;
    logic             IF_ID_write_o;
    logic             ID_EX_write_o;
    logic             IF_ID_flush_o;
    logic             ID_EX_flush_o;
    logic             EX_MEM_bubble_o;
    logic             mc_start_o;
    logic             mc_timeout_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] mc_stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ID_EX_MemRead_i, ID_EX_RD_i, IF_ID_RS1_i, IF_ID_RS2_i,
               IF_ID_UsesRs2_i, branch_taken_i, ID_EX_Multicycle_i, mc_done_i,
        input  pc_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o,
               ID_EX_flush_o, EX_MEM_bubble_o, mc_start_o, mc_timeout_o,
               lu_stall_cnt_o, mc_stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ID_EX_MemRead_i, ID_EX_RD_i, IF_ID_RS1_i, IF_ID_RS2_i,
               IF_ID_UsesRs2_i, branch_taken_i, ID_EX_Multicycle_i, mc_done_i,
        output pc_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o,
               ID_EX_flush_o, EX_MEM_bubble_o, mc_start_o, mc_timeout_o,
               lu_stall_cnt_o, mc_stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32I core.
// Handles load-use stalls, taken-branch squash (FLUSH_CYCLES long) and
// stall sequencing for the multi-cycle EX unit with timeout.
// Optional: define HAZARD_PERF_EN to build the performance counters;
// otherwise the counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] fl_cnt_q, fl_cnt_d;
    logic [7:0] mc_cnt_q, mc_cnt_d;
    logic       mc_timeout_q, mc_timeout_d;
    logic       lu_hazard;

    logic pc_write, if_id_write, id_ex_write;
    logic if_id_flush, id_ex_flush, ex_mem_bubble, mc_start;

    // Load-use hazard: load in EX writes a register ID is about to read (x0 never)
    always_comb begin
        lu_hazard = hz.ID_EX_MemRead_i && (hz.ID_EX_RD_i != 5'd0) &&
                    ((hz.ID_EX_RD_i == hz.IF_ID_RS1_i) ||
                     (hz.IF_ID_UsesRs2_i && (hz.ID_EX_RD_i == hz.IF_ID_RS2_i)));
    end

    // Next-state and control decode; priority in RUN is branch > multicycle > load-use
    always_comb begin
        state_d       = state_q;
        fl_cnt_d      = fl_cnt_q;
        mc_cnt_d      = mc_cnt_q;
        mc_timeout_d  = mc_timeout_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_start      = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.branch_taken_i) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d  = FLUSH;
                        fl_cnt_d = 3'(FLUSH_CYCLES - 1);
                    end
                end else if (hz.ID_EX_Multicycle_i) begin
                    mc_start      = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_d       = MC_WAIT;
                    mc_cnt_d      = '0;
                end else if (lu_hazard) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                fl_cnt_d    = fl_cnt_q - 3'd1;
                if (fl_cnt_q <= 3'd1) begin
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                // Release cycles keep the RUN defaults (writes on, no bubble)
                if (hz.mc_done_i) begin
                    state_d = RUN;
                end else if (mc_cnt_q >= 8'(MC_TIMEOUT)) begin
                    mc_timeout_d = 1'b1;
                    state_d      = RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    mc_cnt_d      = mc_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset overrides the decode so the pipeline is held and filled with NOPs
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
            mc_start      = 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fl_cnt_q     <= '0;
            mc_cnt_q     <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fl_cnt_q     <= fl_cnt_d;
            mc_cnt_q     <= mc_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign hz.pc_write_o      = pc_write;
    assign hz.IF_ID_write_o   = if_id_write;
    assign hz.ID_EX_write_o   = id_ex_write;
    assign hz.IF_ID_flush_o   = if_id_flush;
    assign hz.ID_EX_flush_o   = id_ex_flush;
    assign hz.EX_MEM_bubble_o = ex_mem_bubble;
    assign hz.mc_start_o      = mc_start;
    assign hz.mc_timeout_o    = mc_timeout_q;

`ifdef HAZARD_PERF_EN
    logic             lu_evt, mc_evt, fl_evt;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mcs_cnt_q, mcs_cnt_d;
    logic [CNT_W-1:0] flc_cnt_q, flc_cnt_d;

    // Event decode and wrapping increments for the performance counters
    always_comb begin
        lu_evt    = (state_q == RUN) && !hz.branch_taken_i &&
                    !hz.ID_EX_Multicycle_i && lu_hazard;
        mc_evt    = (state_q == MC_WAIT) ||
                    ((state_q == RUN) && !hz.branch_taken_i && hz.ID_EX_Multicycle_i);
        fl_evt    = (state_q == FLUSH) || ((state_q == RUN) && hz.branch_taken_i);
        lu_cnt_d  = lu_evt ? lu_cnt_q  + 1'b1 : lu_cnt_q;
        mcs_cnt_d = mc_evt ? mcs_cnt_q + 1'b1 : mcs_cnt_q;
        flc_cnt_d = fl_evt ? flc_cnt_q + 1'b1 : flc_cnt_q;
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q  <= '0;
            mcs_cnt_q <= '0;
            flc_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mcs_cnt_q <= mcs_cnt_d;
            flc_cnt_q <= flc_cnt_d;
        end
    end

    assign hz.lu_stall_cnt_o = lu_cnt_q;
    assign hz.mc_stall_cnt_o = mcs_cnt_q;
    assign hz.flush_cnt_o    = flc_cnt_q;
`else
    assign hz.lu_stall_cnt_o = '0;
    assign hz.mc_stall_cnt_o = '0;
    assign hz.flush_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. dut_a: FLUSH_CYCLES=3, MC_TIMEOUT=64;
// dut_b: FLUSH_CYCLES=1, MC_TIMEOUT=4. Both see identical stimulus.
// Control vector order: {pc_write, IF_ID_write, ID_EX_write,
//                        IF_ID_flush, ID_EX_flush, EX_MEM_bubble, mc_start}
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] C_RST   = 7'b000_1110;
    localparam logic [6:0] C_RUN   = 7'b111_0000;
    localparam logic [6:0] C_LU    = 7'b001_0100;
    localparam logic [6:0] C_BR    = 7'b111_1100;
    localparam logic [6:0] C_START = 7'b000_0011;
    localparam logic [6:0] C_WAIT  = 7'b000_0010;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) if_a ();
    hazard_ctrl_if #(.CNT_W(32)) if_b ();

    hazard_ctrl #(.FLUSH_CYCLES(3), .MC_TIMEOUT(64), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .hz(if_a)
    );
    hazard_ctrl #(.FLUSH_CYCLES(1), .MC_TIMEOUT(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .hz(if_b)
    );

    logic [6:0] ctl_a, ctl_b;
    assign ctl_a = {if_a.pc_write_o, if_a.IF_ID_write_o, if_a.ID_EX_write_o,
                    if_a.IF_ID_flush_o, if_a.ID_EX_flush_o, if_a.EX_MEM_bubble_o,
                    if_a.mc_start_o};
    assign ctl_b = {if_b.pc_write_o, if_b.IF_ID_write_o, if_b.ID_EX_write_o,
                    if_b.IF_ID_flush_o, if_b.ID_EX_flush_o, if_b.EX_MEM_bubble_o,
                    if_b.mc_start_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2, input logic br,
                         input logic mc, input logic done);
        if_a.ID_EX_MemRead_i = mr;    if_b.ID_EX_MemRead_i = mr;
        if_a.ID_EX_RD_i = rd;         if_b.ID_EX_RD_i = rd;
        if_a.IF_ID_RS1_i = rs1;       if_b.IF_ID_RS1_i = rs1;
        if_a.IF_ID_RS2_i = rs2;       if_b.IF_ID_RS2_i = rs2;
        if_a.IF_ID_UsesRs2_i = u2;    if_b.IF_ID_UsesRs2_i = u2;
        if_a.branch_taken_i = br;     if_b.branch_taken_i = br;
        if_a.ID_EX_Multicycle_i = mc; if_b.ID_EX_Multicycle_i = mc;
        if_a.mc_done_i = done;        if_b.mc_done_i = done;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset values, including with every request asserted
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ctl_a", 32'(ctl_a), 32'(C_RST));
        check("rst_ctl_b", 32'(ctl_b), 32'(C_RST));
        check("rst_timeout_a", 32'(if_a.mc_timeout_o), 32'd0);
        check("rst_lu_cnt", if_a.lu_stall_cnt_o, 32'd0);
        drive(1, 5, 5, 0, 0, 1, 1, 0);
        check("rst_busy_ctl", 32'(ctl_a), 32'(C_RST));
        cyc();
        cyc();
        rst_n = 1'b1;

        // mc_done in RUN has no effect
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("run_done_ign", 32'(ctl_a), 32'(C_RUN));

        // Load-use on rs1, one-cycle stall
        cyc(); drive(1, 5, 5, 0, 0, 0, 0, 0);
        check("lu_rs1", 32'(ctl_a), 32'(C_LU));
        cyc(); drive(0, 5, 5, 0, 0, 0, 0, 0);
        check("lu_clear", 32'(ctl_a), 32'(C_RUN));
        check("lu_cnt1", if_a.lu_stall_cnt_o, PERF ? 32'd1 : 32'd0);
        cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("lu_x0", 32'(ctl_a), 32'(C_RUN));

        // rs2 only counts when the instruction uses it
        cyc(); drive(1, 7, 3, 7, 0, 0, 0, 0);
        check("lu_rs2_unused", 32'(ctl_a), 32'(C_RUN));
        cyc(); drive(1, 7, 3, 7, 1, 0, 0, 0);
        check("lu_rs2_used", 32'(ctl_a), 32'(C_LU));
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_rs2_clear", 32'(ctl_a), 32'(C_RUN));
        check("lu_cnt2", if_a.lu_stall_cnt_o, PERF ? 32'd2 : 32'd0);

        // Branch wins over multicycle and load-use; 3-cycle flush on dut_a
        cyc(); drive(1, 5, 5, 0, 0, 1, 1, 0);
        check("br_ctl_a", 32'(ctl_a), 32'(C_BR));
        check("br_ctl_b", 32'(ctl_b), 32'(C_BR));
        cyc(); drive(0, 0, 0, 0, 0, 1, 1, 0);
        check("flush2_ign_br_mc", 32'(ctl_a), 32'(C_BR));
        cyc(); drive(1, 5, 5, 0, 0, 0, 0, 0);
        check("flush3_ign_lu", 32'(ctl_a), 32'(C_BR));
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_done", 32'(ctl_a), 32'(C_RUN));
        check("flush_cnt", if_a.flush_cnt_o, PERF ? 32'd3 : 32'd0);

        // Multicycle op, done arrives 5 cycles after start
        cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
        check("mc_start_a", 32'(ctl_a), 32'(C_START));
        for (int i = 0; i < 4; i++) begin
            cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
            check("mc_wait_a", 32'(ctl_a), 32'(C_WAIT));
        end
        cyc(); drive(0, 0, 0, 0, 0, 0, 1, 1);
        check("mc_release_a", 32'(ctl_a), 32'(C_RUN));
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("mc_after_a", 32'(ctl_a), 32'(C_RUN));
        check("mc_cnt", if_a.mc_stall_cnt_o, PERF ? 32'd6 : 32'd0);
        check("mc_no_to_a", 32'(if_a.mc_timeout_o), 32'd0);
        check("mc_no_to_b", 32'(if_b.mc_timeout_o), 32'd0);

        // Timeout on dut_b (MC_TIMEOUT=4): 4 stalled wait cycles, then release
        cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
        check("to_start_b", 32'(ctl_b), 32'(C_START));
        for (int i = 0; i < 4; i++) begin
            cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
            check("to_wait_b", 32'(ctl_b), 32'(C_WAIT));
        end
        cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
        check("to_release_b", 32'(ctl_b), 32'(C_RUN));
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("to_flag_b", 32'(if_b.mc_timeout_o), 32'd1);
        check("to_run_b", 32'(ctl_b), 32'(C_RUN));
        check("long_wait_a", 32'(ctl_a), 32'(C_WAIT));
        cyc(); drive(1, 5, 5, 0, 0, 0, 0, 0);
        check("to_sticky_b", 32'(if_b.mc_timeout_o), 32'd1);
        check("lu_after_to_b", 32'(ctl_b), 32'(C_LU));
        check("wait_ign_lu_a", 32'(ctl_a), 32'(C_WAIT));

        // Asynchronous reset in the middle of MC_WAIT
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctl_a", 32'(ctl_a), 32'(C_RST));
        check("midrst_to_b", 32'(if_b.mc_timeout_o), 32'd0);
        check("midrst_mc_cnt", if_a.mc_stall_cnt_o, 32'd0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_run", 32'(ctl_a), 32'(C_RUN));
        cyc(); drive(1, 5, 5, 0, 0, 0, 0, 0);
        check("post_rst_lu", 32'(ctl_a), 32'(C_LU));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage RV32I core; drives PC/IF_ID/ID_EX write enables, flushes and EX/MEM bubble insertion.
- Complements operand forwarding by handling what forwarding cannot: load-use stalls, taken-branch squash (optionally multi-cycle for slow fetch), and stall sequencing for a multi-cycle EX unit (MUL/DIV) with start/done handshake and timeout.

Parameters:
- FLUSH_CYCLES, 1, cycles IF_ID_flush_o held per taken branch (legal 1..4).
- MC_TIMEOUT, 64, max MC_WAIT cycles before forced release (legal 2..255).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- ID_EX_RD_i  in  5  destination of instruction in EX
- IF_ID_RS1_i  in  5  rs1 of instruction in ID
- IF_ID_RS2_i  in  5  rs2 of instruction in ID
- IF_ID_UsesRs2_i  in  1  ID instruction reads rs2
- branch_taken_i  in  1  branch/jump resolved taken in EX
- ID_EX_Multicycle_i  in  1  instruction in EX needs multi-cycle unit
- mc_done_i  in  1  multi-cycle unit result valid
- pc_write_o  out  1  PC update enable
- IF_ID_write_o  out  1  IF/ID register enable
- ID_EX_write_o  out  1  ID/EX register enable
- IF_ID_flush_o  out  1  load NOP into IF/ID
- ID_EX_flush_o  out  1  load NOP into ID/EX
- EX_MEM_bubble_o  out  1  load NOP into EX/MEM
- mc_start_o  out  1  one-cycle start pulse to multi-cycle unit
- mc_timeout_o  out  1  sticky timeout flag
- lu_stall_cnt_o, mc_stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

Behaviour:
- Clock/reset: one clock (clk); reset rst_n asynchronous, active-low. State, counters, mc_timeout_o clear asynchronously.
- Outputs are combinational decode of state + inputs (same-cycle effect). While rst_n=0: pc_write/IF_ID_write/ID_EX_write=0, IF_ID_flush/ID_EX_flush/EX_MEM_bubble=1, mc_start=0, mc_timeout=0, counters=0.
- States: RUN, FLUSH, MC_WAIT. Reset -> RUN.
- RUN defaults: all writes 1, flushes/bubble 0. Priority per cycle: branch > multicycle > load-use.
- Branch (RUN, branch_taken_i=1): pc_write=1, IF_ID_flush=1, ID_EX_flush=1; ID_EX_Multicycle_i and load-use ignored. FLUSH_CYCLES=1 -> stay RUN; else -> FLUSH, counter=FLUSH_CYCLES-1.
- FLUSH: pc_write=1, IF_ID_flush=1, ID_EX_flush=1; decrement counter; at 1 -> RUN. branch_taken_i, load-use, ID_EX_Multicycle_i ignored (EX holds bubble).
- Multicycle start (RUN, ID_EX_Multicycle_i=1, no branch): mc_start_o=1 this cycle only; pc_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1; -> MC_WAIT, wait counter=0. mc_done_i ignored in RUN.
- MC_WAIT: pc_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1, counter++. mc_done_i=1: release this cycle (all writes 1, bubble 0), -> RUN. Counter reaching MC_TIMEOUT without done: set mc_timeout_o (sticky until reset), release same way, -> RUN. branch_taken_i ignored.
- Load-use (RUN, no branch, no multicycle): hazard = ID_EX_MemRead_i & ID_EX_RD_i!=0 & (RD==RS1 | (UsesRs2 & RD==RS2)). Then pc_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly that cycle; stays RUN (bubble clears the condition next cycle). RD=x0 never stalls.
- Reset asserted mid-MC_WAIT/FLUSH: immediate return to reset outputs; no mc_start on release.

Optional Feature:
- HAZARD_PERF_EN defined: counters increment once per cycle of load-use stall (lu), MC_WAIT or start cycle (mc), branch or FLUSH cycle (flush); wrap modulo 2^CNT_W. Undefined: counter outputs constant 0, no counter flops.

Test Plan:
- Load x5 in EX (MemRead=1,RD=5), ID rs1=5 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle all writes 1; lu count=1. Same with RD=0 -> no stall.
- RD=7, rs2=7, UsesRs2=0 -> no stall; UsesRs2=1 -> stall.
- branch_taken_i=1 with FLUSH_CYCLES=3 -> IF_ID_flush=1 for 3 cycles, pc_write=1 throughout; second branch pulse during FLUSH ignored; flush count=3.
- ID_EX_Multicycle_i=1, mc_done_i after 5 cycles -> mc_start one pulse, stall/bubble 5 cycles, release on done cycle, mc_stall count=6.
- MC_TIMEOUT=4, mc_done never -> release after 4 wait cycles, mc_timeout_o=1 and stays 1 until rst_n low.
- Branch + load-use + Multicycle same cycle -> branch response only, no mc_start; rst_n low mid-MC_WAIT -> reset outputs, state RUN.
